// File: rtl/data_axi_pkg.sv
// Shared types, AXI tie-off constants and the byte-strobe rule for the data-side AXI bridge.
// Optional posted-write behaviour is selected in the top by DATA_AXI_POSTED_WR_EN.
package data_axi_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned STRB_W   = 4;
   localparam int unsigned SIZE_W   = 2;
   localparam int unsigned AXSIZE_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP
   } state_e;

   localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
   localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
   localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

   localparam logic [3:0] AXI_ID         = 4'd1;
   localparam logic [3:0] AXI_LEN        = 4'd0;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic       AXI_WLAST      = 1'b1;
   localparam logic [1:0] AXI_LOCK       = 2'b00;
   localparam logic [3:0] AXI_CACHE      = 4'b0000;
   localparam logic [2:0] AXI_PROT       = 3'b000;

   // Latched request payload, held stable for the whole AXI transaction.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [SIZE_W-1:0] size;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   // Size 2'b11 is illegal and falls through to a full-word strobe.
   function automatic logic [STRB_W-1:0] wstrb_f(input logic [SIZE_W-1:0] size,
                                                 input logic [1:0]        addr_lo);
      logic [STRB_W-1:0] strb;
      case (size)
         SIZE_BYTE: strb = 4'b0001 << addr_lo;
         SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:   strb = 4'b1111;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/data_wstrb_gen.sv
// Combinational write-strobe generator from access size and low address bits.
module data_wstrb_gen
   import data_axi_pkg::*;
(
   input  logic [SIZE_W-1:0] size_i,
   input  logic [1:0]        addr_lo_i,
   output logic [STRB_W-1:0] wstrb_o
);

   assign wstrb_o = wstrb_f(size_i, addr_lo_i);

endmodule

// File: rtl/data_sram_axi_bridge.sv
// sram-like to single-beat AXI3 bridge for the CPU data port, one transaction outstanding.
// Define DATA_AXI_POSTED_WR_EN to complete writes on AW/W handshake instead of on B.
module data_sram_axi_bridge
   import data_axi_pkg::*;
(
   input  logic                clk,
   input  logic                rst,

   input  logic                data_req,
   input  logic                data_wr,
   input  logic [SIZE_W-1:0]   data_size,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,

   output logic [ADDR_W-1:0]   araddr,
   output logic [AXSIZE_W-1:0] arsize,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic                rvalid,
   output logic                rready,

   output logic [ADDR_W-1:0]   awaddr,
   output logic [AXSIZE_W-1:0] awsize,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [STRB_W-1:0]   wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic                bvalid,
   output logic                bready
);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [STRB_W-1:0] wstrb_c;
   logic              aw_now_c, w_now_c;
`ifdef DATA_AXI_POSTED_WR_EN
   logic              b_pending_q, b_pending_d;
`endif

   data_wstrb_gen u_wstrb_gen (
      .size_i    (data_size),
      .addr_lo_i (data_addr[1:0]),
      .wstrb_o   (wstrb_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         req_q       <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rdata_q     <= '0;
`ifdef DATA_AXI_POSTED_WR_EN
         b_pending_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rdata_q     <= rdata_d;
`ifdef DATA_AXI_POSTED_WR_EN
         b_pending_q <= b_pending_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      rdata_d      = rdata_q;
`ifdef DATA_AXI_POSTED_WR_EN
      b_pending_d  = b_pending_q;
`endif
      aw_now_c     = 1'b0;
      w_now_c      = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = rdata_q;
      arvalid      = 1'b0;
      rready       = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;

      case (state_q)
         IDLE: begin
`ifdef DATA_AXI_POSTED_WR_EN
            data_addr_ok = data_req & ~rst & ~b_pending_q;
`else
            data_addr_ok = data_req & ~rst;
`endif
            if (data_addr_ok) begin
               req_d.addr  = data_addr;
               req_d.size  = data_size;
               req_d.wdata = data_wdata;
               req_d.wstrb = wstrb_c;
               state_d     = data_wr ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (rvalid) begin
               data_data_ok = 1'b1;
               data_rdata   = rdata;
               rdata_d      = rdata;
               state_d      = IDLE;
            end
         end
         WR_REQ: begin
            // Each channel's valid drops once its own handshake has been seen.
            awvalid  = ~aw_done_q;
            wvalid   = ~w_done_q;
            aw_now_c = aw_done_q | (awvalid & awready);
            w_now_c  = w_done_q | (wvalid & wready);
            if (aw_now_c && w_now_c) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
`ifdef DATA_AXI_POSTED_WR_EN
               data_data_ok = 1'b1;
               b_pending_d  = 1'b1;
`endif
            end else begin
               aw_done_d = aw_now_c;
               w_done_d  = w_now_c;
            end
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               state_d = IDLE;
`ifdef DATA_AXI_POSTED_WR_EN
               b_pending_d = 1'b0;
`else
               data_data_ok = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign araddr = req_q.addr;
   assign arsize = {1'b0, req_q.size};
   assign awaddr = req_q.addr;
   assign awsize = {1'b0, req_q.size};
   assign wdata  = req_q.wdata;
   assign wstrb  = req_q.wstrb;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Self-checking bench for data_sram_axi_bridge; honours DATA_AXI_POSTED_WR_EN when defined.
module tb_data_sram_axi_bridge;

`ifdef DATA_AXI_POSTED_WR_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   data_sram_axi_bridge dut (
      .clk(clk), .rst(rst),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   // Strobe from byte count and naturally aligned offset.
   function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [1:0] a);
      int bytes, off;
      bytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off   = int'(a) - (int'(a) % bytes);
      return 4'(((1 << bytes) - 1) << off);
   endfunction

   task automatic drive_idle();
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
   endtask

   // One transaction, cycle 0 = request cycle; slave timing chosen by the delays.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int ar_dly, input int r_dly, input int aw_dly,
                          input int w_dly, input int b_dly);
      int m, ok_c, end_c;
      logic [3:0] exp_strb;
      bit e_arv, e_rr, e_awv, e_wv, e_br, e_aok, e_dok;
      exp_strb = model_strb(size, addr[1:0]);
      m = (aw_dly > w_dly) ? aw_dly : w_dly;
      if (!wr) begin
         ok_c = 2 + ar_dly + r_dly; end_c = ok_c;
      end else if (POSTED) begin
         ok_c = 1 + m; end_c = 2 + m + b_dly;
      end else begin
         ok_c = 2 + m + b_dly; end_c = ok_c;
      end
      for (int c = 0; c <= end_c; c++) begin
         @(negedge clk);
         data_req = 1'b1;
         if (c == 0) begin
            data_wr = wr; data_addr = addr; data_size = size; data_wdata = wd;
         end else begin
            data_wr = 1'($urandom); data_addr = $urandom; data_size = 2'($urandom);
            data_wdata = $urandom;
         end
         arready = !wr && (c == 1 + ar_dly);
         rvalid  = !wr && (c == 2 + ar_dly + r_dly);
         rdata   = rvalid ? rd : $urandom;
         awready = wr && (c == 1 + aw_dly);
         wready  = wr && (c == 1 + w_dly);
         bvalid  = wr && (c == 2 + m + b_dly);
         #1;
         e_arv = !wr && c >= 1 && c <= 1 + ar_dly;
         e_rr  = !wr && c >= 2 + ar_dly && c <= ok_c;
         e_awv = wr && c >= 1 && c <= 1 + aw_dly;
         e_wv  = wr && c >= 1 && c <= 1 + w_dly;
         e_br  = wr && c >= 2 + m && c <= 2 + m + b_dly;
         e_aok = (c == 0);
         e_dok = (c == ok_c);
         tests += 7;
         if (arvalid !== e_arv) begin fails++; $display("FAIL arvalid c=%0d got %b exp %b", c, arvalid, e_arv); end
         if (rready !== e_rr) begin fails++; $display("FAIL rready c=%0d got %b exp %b", c, rready, e_rr); end
         if (awvalid !== e_awv) begin fails++; $display("FAIL awvalid c=%0d got %b exp %b", c, awvalid, e_awv); end
         if (wvalid !== e_wv) begin fails++; $display("FAIL wvalid c=%0d got %b exp %b", c, wvalid, e_wv); end
         if (bready !== e_br) begin fails++; $display("FAIL bready c=%0d got %b exp %b", c, bready, e_br); end
         if (data_addr_ok !== e_aok) begin fails++; $display("FAIL addr_ok c=%0d got %b exp %b", c, data_addr_ok, e_aok); end
         if (data_data_ok !== e_dok) begin fails++; $display("FAIL data_ok c=%0d got %b exp %b", c, data_data_ok, e_dok); end
         if (e_arv) begin
            tests += 2;
            if (araddr !== addr) begin fails++; $display("FAIL araddr c=%0d got %h exp %h", c, araddr, addr); end
            if (arsize !== {1'b0, size}) begin fails++; $display("FAIL arsize c=%0d got %b exp %b", c, arsize, {1'b0, size}); end
         end
         if (e_awv) begin
            tests += 2;
            if (awaddr !== addr) begin fails++; $display("FAIL awaddr c=%0d got %h exp %h", c, awaddr, addr); end
            if (awsize !== {1'b0, size}) begin fails++; $display("FAIL awsize c=%0d got %b exp %b", c, awsize, {1'b0, size}); end
         end
         if (e_wv) begin
            tests += 2;
            if (wdata !== wd) begin fails++; $display("FAIL wdata c=%0d got %h exp %h", c, wdata, wd); end
            if (wstrb !== exp_strb) begin fails++; $display("FAIL wstrb c=%0d got %b exp %b", c, wstrb, exp_strb); end
         end
         if (e_dok && !wr) begin
            tests++;
            if (data_rdata !== rd) begin fails++; $display("FAIL data_rdata c=%0d got %h exp %h", c, data_rdata, rd); end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      logic [8:0] v;
      v = {arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok, 1'b0, 1'b0};
      tests++;
      if (v !== 9'd0) begin fails++; $display("FAIL %s handshake outputs got %b exp 0", tag, v); end
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      tests++;
      if ({araddr, awaddr, wdata, arsize, wstrb} !== '0) begin
         fails++; $display("FAIL reset latched regs got %h exp 0", {araddr, awaddr, wdata, arsize, wstrb});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_word_read();
      run_txn(1'b0, 32'h0000_1000, 2'b10, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
   endtask

   task automatic test_writes();
      run_txn(1'b1, 32'h0000_2003, 2'b00, 32'h1100_0000, 32'h0, 0, 0, 0, 0, 2);
      run_txn(1'b1, 32'h0000_2002, 2'b01, 32'h2233_0000, 32'h0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_write_order();
      run_txn(1'b1, 32'h0000_3000, 2'b10, 32'hA5A5_5A5A, 32'h0, 0, 0, 3, 0, 0);
      run_txn(1'b1, 32'h0000_3004, 2'b10, 32'h0123_4567, 32'h0, 0, 0, 0, 3, 1);
   endtask

   task automatic test_read_delayed();
      run_txn(1'b0, 32'h0000_4001, 2'b00, 32'h0, 32'hCAFE_F00D, 4, 5, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h5000; data_size = 2'b10;
      @(negedge clk);
      data_req = 1'b0; arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      #1;
      tests++;
      if (rready !== 1'b1) begin fails++; $display("FAIL reset_mid rready before reset got %b exp 1", rready); end
      rst = 1'b1; rvalid = 1'b1; rdata = 32'h7777_7777;
      #1;
      check_all_zero("reset_mid");
      @(negedge clk);
      #1;
      check_all_zero("reset_mid_held");
      rst = 1'b0; rvalid = 1'b0;
      run_txn(1'b0, 32'h0000_5004, 2'b10, 32'h0, 32'h1357_9BDF, 1, 0, 0, 0, 0);
   endtask

   task automatic test_posted_write();
      run_txn(1'b1, 32'h0000_6000, 2'b10, 32'hFEED_FACE, 32'h0, 0, 0, 0, 0, 6);
      run_txn(1'b0, 32'h0000_6000, 2'b10, 32'h0, 32'h2468_ACE0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom), $urandom, 2'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)));
      end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_writes();
      test_write_order();
      test_read_delayed();
      test_reset_mid();
      test_posted_write();
      test_back_to_back();
      @(negedge clk);
      drive_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
Downstream stage of the data-side sram-like adapter: accepts one sram-like transaction at a time (req/addr_ok/data_ok) and converts it into a single-beat AXI3 read (AR/R) or write (AW/W/B) on the CPU data port. It sits between the sram-like adapter and the top-level AXI crossbar and keeps at most one transaction outstanding.

Parameters:
none (AXI constant fields live in the shared package and are tied off at top level: id=1, len=0, burst=INCR, wlast=1, lock/cache/prot=0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
data_req  in  1  sram-like request
data_wr  in  1  1=write, 0=read
data_size  in  2  00 byte, 01 half, 10 word
data_addr  in  32  byte address
data_wdata  in  32  write data, byte-lane aligned
data_rdata  out  32  read data, valid when data_data_ok=1
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  one-cycle transaction-complete pulse
araddr  out  32  read address
arsize  out  3  {1'b0,size}
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  read data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  write address
awsize  out  3  {1'b0,size}
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  write data
wstrb  out  4  byte strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- States IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; reset (async) -> IDLE; all valid/ready/ok outputs 0; latched addr/size/wdata/wstrb regs 0.
- IDLE: data_addr_ok = data_req (combinational). On data_req, latch addr, size, wdata and computed wstrb; next state RD_ADDR if ~data_wr else WR_REQ. addr_ok is 0 in every other state, so addr_ok and data_ok are never high in the same cycle.
- wstrb: size 00 -> 4'b0001<<addr[1:0]; 01 -> addr[1] ? 1100 : 0011; 10 -> 1111; size 11 is illegal and treated as word. Address is passed through unaligned-unmodified.
- RD_ADDR: arvalid=1 and held until arready; then RD_DATA. RD_DATA: rready=1; on rvalid: data_data_ok=1, data_rdata=rdata (combinational same cycle), next IDLE. Minimum read latency: req -> data_ok is 2 cycles with zero-wait slave.
- WR_REQ: awvalid and wvalid raised together; sticky flags aw_done/w_done set on each handshake and deassert the corresponding valid; handshakes may complete in either order or the same cycle. When both are done (including the completing cycle) -> WR_RESP and clear the flags.
- WR_RESP: bready=1; on bvalid: data_data_ok=1, next IDLE. data_rdata is don't-care on writes (drive the last read value).
- A new request may be accepted in the cycle after data_data_ok (back-to-back supported, no bubble beyond IDLE).
- rresp/bresp are ignored; rid/bid/rlast are not checked.
- Reset mid-transaction abandons it: valids drop immediately, no data_ok is issued.

Optional Feature:
DATA_AXI_POSTED_WR_EN: when defined, a write pulses data_data_ok as soon as both AW and W have handshaked (leaving WR_REQ), and WR_RESP is entered only to drain B; addr_ok in IDLE is additionally gated by ~b_pending, so a following request waits until bvalid&bready. When undefined, write data_ok waits for B as described above.

Decomposition:
- Package data_axi_pkg: state enum, size codes, AXI constant values (ID, LEN, BURST_INCR, WLAST), and the wstrb function.
- One natural sub-module: data_wstrb_gen (size, addr[1:0] -> wstrb), combinational.

Test Plan:
- Word read 0x1000, arready/rvalid both 1 immediately, rdata=0xDEADBEEF -> arsize=010, addr_ok at cycle 0, data_ok with data_rdata=0xDEADBEEF at cycle 2.
- Byte write addr 0x2003 data 0x11000000 -> wstrb=1000, awsize=000; half write addr 0x2002 -> wstrb=1100; data_ok only after bvalid.
- Write with wready granted 3 cycles before awready, then the reverse order -> each valid drops after its own handshake; exactly one data_ok per write.
- Read with arready delayed 4 cycles and rvalid delayed 5 -> arvalid held stable with araddr constant; addr_ok never reasserted; single data_ok.
- Assert rst during RD_DATA -> all outputs 0 asynchronously, state IDLE, no data_ok; next request completes normally.
- With DATA_AXI_POSTED_WR_EN: write with bvalid delayed 6 cycles -> data_ok right after AW/W complete; next read's addr_ok held low until B handshake.
